// File: rtl/motor_cmd_uart_rx_if.sv
// Serial link bundle between the motor command transmitter and its receiver.
// master: the line-driving / result-observing side. slave: the receiver block.
interface motor_cmd_uart_rx_if;
  logic       rx;
  logic [4:0] motor_cmd;
  logic       cmd_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx,
    input  motor_cmd, cmd_valid, frame_err, busy
  );

  modport slave (
    input  rx,
    output motor_cmd, cmd_valid, frame_err, busy
  );
endinterface

// File: rtl/motor_cmd_uart_rx.sv
// motor_cmd_uart_rx: 8N1 UART receiver for motor command bytes.
// Byte layout: data[7:5] header (must be 000), data[4:0] motor command.
// Optional build macro MOTOR_RX_ONEHOT_CHECK_EN: additionally require data[4:0]
// to be zero or one-hot; anything else is rejected as a frame error.
module motor_cmd_uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  motor_cmd_uart_rx_if.slave   bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_ARM   = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic             r_sync1, r_sync2, r_rx_d;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [1:0]       r_arm_cnt;
  logic [4:0]       r_motor_cmd;
  logic             r_cmd_valid, r_frame_err;

  logic             w_fall;
  logic             w_hdr_ok;
  logic             w_cmd_ok;
  logic             w_accept;

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= bus.rx;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  assign w_fall   = r_rx_d & ~r_sync2;
  assign w_hdr_ok = (r_shift[7:5] == 3'b000);

`ifdef MOTOR_RX_ONEHOT_CHECK_EN
  // Zero or exactly one bit set: x & (x-1) clears the lowest set bit.
  assign w_cmd_ok = ((r_shift[4:0] & (r_shift[4:0] - 5'd1)) == 5'd0);
`else
  assign w_cmd_ok = 1'b1;
`endif

  // Stop bit, header and command checks evaluated at the stop sample.
  assign w_accept = r_sync2 & w_hdr_ok & w_cmd_ok;

  // Frame FSM: baud counting, bit sampling and result strobes.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state     <= S_ARM;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_arm_cnt   <= '0;
      r_motor_cmd <= '0;
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_ARM: begin
          // The synchroniser comes out of reset holding 1, so let it refill
          // from the pin before trusting a high level; a line held low across
          // reset must not look like an idle-then-start sequence.
          if (r_arm_cnt != 2'd3) r_arm_cnt <= r_arm_cnt + 2'd1;
          else if (r_sync2 && r_rx_d) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (w_fall) begin
            r_bit   <= '0;
            r_cnt   <= HALF_LD;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else if (!r_sync2) begin
            r_cnt   <= FULL_LD;
            r_state <= S_DATA;
          end else begin
            r_state <= S_IDLE;  // glitch, not a start bit
          end
        end
        S_DATA: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else begin
            r_cnt   <= FULL_LD;
            r_shift <= {r_sync2, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else begin
            // Leave at the stop midpoint so a following start edge is caught.
            r_state <= S_IDLE;
            if (w_accept) begin
              r_motor_cmd <= r_shift[4:0];
              r_cmd_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end
        default: r_state <= S_ARM;
      endcase
    end
  end

  assign bus.motor_cmd = r_motor_cmd;
  assign bus.cmd_valid = r_cmd_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state == S_START) || (r_state == S_DATA) ||
                         (r_state == S_STOP);

endmodule

// File: tb/tb_motor_cmd_uart_rx.sv
// Directed bench for motor_cmd_uart_rx: frame vector table plus corner sequences.
module tb_motor_cmd_uart_rx;
  localparam int CLKS = 434;

  logic CLOCK_50 = 1'b0;
  logic reset;
  motor_cmd_uart_rx_if u_if();

  motor_cmd_uart_rx #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (u_if.slave)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;
  int cyc = 0;
  int t_valid[$];
  bit busy_seen = 0;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge CLOCK_50) begin
    cyc <= cyc + 1;
    if (u_if.busy) busy_seen <= 1'b1;
    if (u_if.cmd_valid) begin n_valid <= n_valid + 1; t_valid.push_back(cyc); end
    if (u_if.frame_err) n_err <= n_err + 1;
    if (u_if.cmd_valid || u_if.frame_err) begin
      checks++;
      if (u_if.cmd_valid && u_if.frame_err) begin
        errors++;
        $display("FAIL strobe_overlap: valid=%0b err=%0b, required not both", u_if.cmd_valid, u_if.frame_err);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic send_bit(input logic b);
    u_if.rx = b;
    wait_cyc(CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    u_if.rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_v;
    int         exp_e;
    logic [4:0] exp_cmd;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int v0, e0;
    vecs[0] = '{8'h02, 1'b1, 1, 0, 5'h02};
    vecs[1] = '{8'h02, 1'b0, 0, 1, 5'h02};
    vecs[2] = '{8'h22, 1'b1, 0, 1, 5'h02};
`ifdef MOTOR_RX_ONEHOT_CHECK_EN
    vecs[3] = '{8'h06, 1'b1, 0, 1, 5'h02};
    vecs[4] = '{8'h1F, 1'b1, 0, 1, 5'h02};
`else
    vecs[3] = '{8'h06, 1'b1, 1, 0, 5'h06};
    vecs[4] = '{8'h1F, 1'b1, 1, 0, 5'h1F};
`endif
    vecs[5] = '{8'h00, 1'b1, 1, 0, 5'h00};
    vecs[6] = '{8'h10, 1'b1, 1, 0, 5'h10};
    vecs[7] = '{8'h80, 1'b1, 0, 1, 5'h10};
    vecs[8] = '{8'h01, 1'b1, 1, 0, 5'h01};

    // Reset state
    u_if.rx = 1'b1;
    reset = 1'b1;
    wait_cyc(10);
    chk("rst_motor_cmd", u_if.motor_cmd, 0);
    chk("rst_cmd_valid", u_if.cmd_valid, 0);
    chk("rst_frame_err", u_if.frame_err, 0);
    chk("rst_busy", u_if.busy, 0);
    reset = 1'b0;
    wait_cyc(20);

    // Table of single frames
    foreach (vecs[i]) begin
      v0 = n_valid; e0 = n_err;
      send_frame(vecs[i].data, vecs[i].stop);
      wait_cyc(2 * CLKS);
      chk($sformatf("vec%0d_valid", i), n_valid - v0, vecs[i].exp_v);
      chk($sformatf("vec%0d_err", i), n_err - e0, vecs[i].exp_e);
      chk($sformatf("vec%0d_cmd", i), u_if.motor_cmd, vecs[i].exp_cmd);
      chk($sformatf("vec%0d_busy", i), u_if.busy, 0);
    end

    // Back-to-back frames, no idle gap
    t_valid.delete();
    v0 = n_valid;
    send_frame(8'h02, 1'b1);
    send_frame(8'h04, 1'b1);
    wait_cyc(2 * CLKS);
    chk("b2b_count", n_valid - v0, 2);
    if (t_valid.size() == 2) chk("b2b_spacing", t_valid[1] - t_valid[0], 4340);
    else chk("b2b_spacing_samples", t_valid.size(), 2);
    chk("b2b_cmd", u_if.motor_cmd, 5'h04);

    // 100-cycle glitch: false start
    v0 = n_valid; e0 = n_err;
    busy_seen = 1'b0;
    u_if.rx = 1'b0;
    wait_cyc(100);
    u_if.rx = 1'b1;
    wait_cyc(400);
    chk("glitch_busy_seen", busy_seen, 1);
    chk("glitch_busy_end", u_if.busy, 0);
    chk("glitch_strobes", (n_valid - v0) + (n_err - e0), 0);
    chk("glitch_cmd", u_if.motor_cmd, 5'h04);

    // Reset during data bit 4 of 8'h08, line held low after release
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i == 3);
    u_if.rx = 1'b0;
    wait_cyc(200);
    reset = 1'b1;
    wait_cyc(10);
    reset = 1'b0;
    v0 = n_valid; e0 = n_err;
    busy_seen = 1'b0;
    wait_cyc(2000);
    chk("rstmid_strobes", (n_valid - v0) + (n_err - e0), 0);
    chk("rstmid_busy_seen", busy_seen, 0);
    chk("rstmid_cmd", u_if.motor_cmd, 0);
    u_if.rx = 1'b1;
    wait_cyc(20);
    chk("rstmid_busy_high_line", busy_seen, 0);
    send_frame(8'h01, 1'b1);
    wait_cyc(2 * CLKS);
    chk("rstmid_valid", n_valid - v0, 1);
    chk("rstmid_err", n_err - e0, 0);
    chk("rstmid_final_cmd", u_if.motor_cmd, 5'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
